// File: rtl/div_share_sched.sv
// Two-requester front end for one fixed-latency signed divider: round-robin
// grant, operand issue register, tag pipeline for result routing, in-flight count.
module div_share_sched #(
  parameter int DIV_WIDTH   = 32,
  parameter int RES_WIDTH   = 64,
  parameter int DIV_LATENCY = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [DIV_WIDTH-1:0] a_dividend,
  input  logic [DIV_WIDTH-1:0] a_divisor,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [DIV_WIDTH-1:0] b_dividend,
  input  logic [DIV_WIDTH-1:0] b_divisor,
  output logic                 div_valid,
  output logic [DIV_WIDTH-1:0] div_dividend,
  output logic [DIV_WIDTH-1:0] div_divisor,
  input  logic [RES_WIDTH-1:0] div_result,
  output logic                 a_res_valid,
  output logic [RES_WIDTH-1:0] a_result,
  output logic                 a_div_zero,
  output logic                 b_res_valid,
  output logic [RES_WIDTH-1:0] b_result,
  output logic                 b_div_zero,
  output logic                 idle
);

  localparam int TL    = DIV_LATENCY;
  localparam int CNT_W = $clog2(DIV_LATENCY + 3);

  logic                 last_b_q, last_b_d;
  logic                 div_valid_q, div_valid_d;
  logic [DIV_WIDTH-1:0] dd_q, dd_d, dv_q, dv_d;
  logic [TL:0]          tag_vld_q, tag_vld_d;
  logic [TL:0]          tag_id_q, tag_id_d;
  logic [TL:0]          tag_zero_q, tag_zero_d;
  logic                 a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  logic [RES_WIDTH-1:0] a_res_q, a_res_d, b_res_q, b_res_d;
  logic                 a_zero_q, a_zero_d, b_zero_q, b_zero_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 hs;
  logic [DIV_WIDTH-1:0] sel_dd, sel_dv;
  logic                 out_vld, out_b, out_zero, res_out;
  logic [RES_WIDTH-1:0] res_val;

  // Pointer holds the last winner; ties go to the other requester.
  assign a_ready = ~rst & a_valid & (~b_valid | last_b_q);
  assign b_ready = ~rst & b_valid & (~a_valid | ~last_b_q);
  assign hs      = a_ready | b_ready;
  assign sel_dd  = b_ready ? b_dividend : a_dividend;
  assign sel_dv  = b_ready ? b_divisor  : a_divisor;

  assign out_vld  = tag_vld_q[TL];
  assign out_b    = tag_id_q[TL];
  assign out_zero = tag_zero_q[TL];
  assign res_val  = out_zero ? '0 : div_result;
  assign res_out  = a_rv_q | b_rv_q;

  always_comb begin
    last_b_d    = last_b_q;
    div_valid_d = hs;
    dd_d        = dd_q;
    dv_d        = dv_q;
    a_rv_d      = 1'b0;
    b_rv_d      = 1'b0;
    a_res_d     = a_res_q;
    b_res_d     = b_res_q;
    a_zero_d    = a_zero_q;
    b_zero_d    = b_zero_q;
    cnt_d       = cnt_q;

    if (hs) begin
      last_b_d = b_ready;
      dd_d     = sel_dd;
      dv_d     = sel_dv;
    end

    tag_vld_d  = {tag_vld_q[TL-1:0], hs};
    tag_id_d   = {tag_id_q[TL-1:0], b_ready};
    tag_zero_d = {tag_zero_q[TL-1:0], (sel_dv == '0)};

    if (out_vld && !out_b) begin
      a_rv_d   = 1'b1;
      a_res_d  = res_val;
      a_zero_d = out_zero;
    end
    if (out_vld && out_b) begin
      b_rv_d   = 1'b1;
      b_res_d  = res_val;
      b_zero_d = out_zero;
    end

    // Count leaves the in-flight set when the result is visible to the requester.
    case ({hs, res_out})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b_q    <= 1'b1;
      div_valid_q <= 1'b0;
      dd_q        <= '0;
      dv_q        <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      tag_zero_q  <= '0;
      a_rv_q      <= 1'b0;
      b_rv_q      <= 1'b0;
      a_res_q     <= '0;
      b_res_q     <= '0;
      a_zero_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      last_b_q    <= last_b_d;
      div_valid_q <= div_valid_d;
      dd_q        <= dd_d;
      dv_q        <= dv_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      tag_zero_q  <= tag_zero_d;
      a_rv_q      <= a_rv_d;
      b_rv_q      <= b_rv_d;
      a_res_q     <= a_res_d;
      b_res_q     <= b_res_d;
      a_zero_q    <= a_zero_d;
      b_zero_q    <= b_zero_d;
      cnt_q       <= cnt_d;
    end
  end

  assign div_valid    = div_valid_q;
  assign div_dividend = dd_q;
  assign div_divisor  = dv_q;
  assign a_res_valid  = a_rv_q;
  assign a_result     = a_res_q;
  assign a_div_zero   = a_zero_q;
  assign b_res_valid  = b_rv_q;
  assign b_result     = b_res_q;
  assign b_div_zero   = b_zero_q;
  assign idle         = (cnt_q == '0);

endmodule
